spi_master_node: RTL and testbench

- Master-side serial link controller that drives the subnode's sdi, in_clk and cs lines from the host side ("Master World").
- On start it shifts the 128-bit plaintext/ciphertext block out MSB-first, followed by the expanded key.
- It then idles the serial clock for a fixed wait window while the enc/dec slave runs.
- Finally it shifts the 128-bit result back in from sdo and presents it in parallel with a one-cycle done pulse.

---
 rtl/spi_master_node_pkg.sv | 19 +
 rtl/spi_clk_gen.sv | 38 +++
 rtl/spi_master_node.sv | 136 +++++++++++++
 tb/tb_spi_master_node.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/spi_master_node_pkg.sv
// Shared sizing and state encoding for the master-side serial link controller.
package spi_master_node_pkg;

    localparam int unsigned NB      = 4;
    localparam int unsigned NR      = 14;
    localparam int unsigned MSG_W   = 8 * 4 * NB;
    localparam int unsigned KEY_W   = 32 * NB * (NR + 1);
    localparam int unsigned FRAME_W = MSG_W + KEY_W;
    localparam int unsigned CNT_W   = $clog2(FRAME_W + 1);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        SEND = 3'd1,
        WAIT = 3'd2,
        RECV = 3'd3,
        DONE = 3'd4
    } state_t;

endpackage

// File: rtl/spi_clk_gen.sv
// Serial clock divider: toggles sclk every CLK_DIV cycles while running and
// flags the cycle in which each rising or falling toggle is taken.
module spi_clk_gen #(
    parameter int unsigned CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic clear,
    output logic sclk,
    output logic rise_tick_c,
    output logic fall_tick_c
);

    localparam int unsigned DIV_W = $clog2(CLK_DIV + 1);

    logic [DIV_W-1:0] div_cnt;
    logic             term_c;

    assign term_c      = run && (div_cnt == DIV_W'(CLK_DIV - 1));
    assign rise_tick_c = term_c && !sclk;
    assign fall_tick_c = term_c && sclk;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            div_cnt <= '0;
            sclk    <= 1'b0;
        end else if (run) begin
            if (term_c) begin
                div_cnt <= '0;
                sclk    <= ~sclk;
            end else begin
                div_cnt <= div_cnt + DIV_W'(1);
            end
        end
    end

endmodule

// File: rtl/spi_master_node.sv
// Master-side link controller: shifts message+key out, idles a wait window,
// then shifts the result back in and presents it with a one-cycle done pulse.
module spi_master_node
    import spi_master_node_pkg::*;
#(
    parameter int unsigned CLK_DIV  = 2,
    parameter int unsigned WAIT_CYC = 24
) (
    input  logic             in_clk,
    input  logic             rst,
    input  logic             start,
    input  logic [MSG_W-1:0] msg_in,
    input  logic [KEY_W-1:0] key_in,
    input  logic             sdo,
    output logic             sclk,
    output logic             sdi,
    output logic             cs_real_world,
    output logic             busy,
    output logic             done,
    output logic [MSG_W-1:0] msg_out
);

    state_t             state;
    state_t             state_nxt;
    logic [FRAME_W-1:0] tx_sr;
    logic [MSG_W-1:0]   rx_sr;
    logic [CNT_W-1:0]   bit_cnt;
    logic               rise_tick_c;
    logic               fall_tick_c;
    logic               run_c;
    logic               clear_c;
    logic               accept_c;
    logic               phase_end_c;

    assign run_c   = (state == SEND) || (state == WAIT) || (state == RECV);
    assign clear_c = accept_c || (state == DONE);

    spi_clk_gen #(
        .CLK_DIV(CLK_DIV)
    ) u_clk_gen (
        .clk        (in_clk),
        .rst        (rst),
        .run        (run_c),
        .clear      (clear_c),
        .sclk       (sclk),
        .rise_tick_c(rise_tick_c),
        .fall_tick_c(fall_tick_c)
    );

    always_ff @(posedge in_clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Each phase ends on the fall_tick that completes its last serial period.
    always_comb begin
        state_nxt   = state;
        accept_c    = 1'b0;
        phase_end_c = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept_c  = 1'b1;
                    state_nxt = SEND;
                end
            end
            SEND: begin
                if (fall_tick_c && (bit_cnt == CNT_W'(FRAME_W - 1))) begin
                    phase_end_c = 1'b1;
                    state_nxt   = WAIT;
                end
            end
            WAIT: begin
                if (fall_tick_c && (bit_cnt == CNT_W'(WAIT_CYC - 1))) begin
                    phase_end_c = 1'b1;
                    state_nxt   = RECV;
                end
            end
            RECV: begin
                if (fall_tick_c && (bit_cnt == CNT_W'(MSG_W - 1))) begin
                    phase_end_c = 1'b1;
                    state_nxt   = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge in_clk) begin
        if (rst) begin
            tx_sr         <= '0;
            rx_sr         <= '0;
            bit_cnt       <= '0;
            sdi           <= 1'b0;
            cs_real_world <= 1'b1;
            busy          <= 1'b0;
            done          <= 1'b0;
            msg_out       <= '0;
        end else begin
            done <= 1'b0;
            if (accept_c) begin
                tx_sr         <= {msg_in, key_in};
                rx_sr         <= '0;
                bit_cnt       <= '0;
                cs_real_world <= 1'b0;
                busy          <= 1'b1;
            end
            // Data launches on the rising edge so the subnode sees it stable at the fall.
            if ((state == SEND) && rise_tick_c) begin
                sdi   <= tx_sr[FRAME_W-1];
                tx_sr <= {tx_sr[FRAME_W-2:0], 1'b0};
            end
            if ((state == RECV) && rise_tick_c) begin
                rx_sr <= {rx_sr[MSG_W-2:0], sdo};
            end
            if (phase_end_c) begin
                bit_cnt <= '0;
                sdi     <= 1'b0;
            end else if (run_c && fall_tick_c) begin
                bit_cnt <= bit_cnt + CNT_W'(1);
            end
            if (state == DONE) begin
                msg_out       <= rx_sr;
                done          <= 1'b1;
                busy          <= 1'b0;
                cs_real_world <= 1'b1;
                sdi           <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_spi_master_node.sv
// Directed bench: subnode model on each DUT captures sdi on sclk falls and
// returns a response on sdo; instances at CLK_DIV 2, 1 and 5.
`timescale 1ns/1ps
module tb_spi_master_node;
    import spi_master_node_pkg::*;

    localparam int unsigned WAIT_CYC = 24;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             start_x;
    logic [MSG_W-1:0] msg_in;
    logic [KEY_W-1:0] key_in;
    logic [MSG_W-1:0] resp;
    int               n_vec = 0;
    int               n_err = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int unsigned DIV = (g == 0) ? 2 : ((g == 1) ? 1 : 5);
        logic               sclk, sdi, cs, busy, done, st;
        logic               sdo = 1'b0;
        logic               sclk_q = 1'b0;
        logic               sdi_q = 1'b0;
        logic [MSG_W-1:0]   msg_out;
        logic [FRAME_W-1:0] cap = '0;
        int                 fall_n = 0;
        int                 done_n = 0;

        assign st = (g == 0) ? start : start_x;

        spi_master_node #(.CLK_DIV(DIV), .WAIT_CYC(WAIT_CYC)) u_dut (
            .in_clk       (clk),
            .rst          (rst),
            .start        (st),
            .msg_in       (msg_in),
            .key_in       (key_in),
            .sdo          (sdo),
            .sclk         (sclk),
            .sdi          (sdi),
            .cs_real_world(cs),
            .busy         (busy),
            .done         (done),
            .msg_out      (msg_out)
        );

        // Subnode: sample sdi on each sclk fall, drive response after the wait window.
        always @(negedge clk) begin
            sclk_q <= sclk;
            sdi_q  <= sdi;
            if (done) done_n <= done_n + 1;
            if (cs) begin
                fall_n <= 0;
                sdo    <= 1'b0;
            end else if (sclk_q && !sclk) begin
                if (fall_n < int'(FRAME_W)) cap[int'(FRAME_W) - 1 - fall_n] <= sdi_q;
                if ((fall_n + 1 >= int'(FRAME_W + WAIT_CYC)) &&
                    (fall_n + 1 < int'(FRAME_W + WAIT_CYC + MSG_W)))
                    sdo <= resp[int'(MSG_W) - 1 - (fall_n + 1 - int'(FRAME_W + WAIT_CYC))];
                fall_n <= fall_n + 1;
            end
        end
    end

    task automatic chk(input string tag, input logic [MSG_W-1:0] obs, input logic [MSG_W-1:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_frame(input string tag, input logic [FRAME_W-1:0] obs, input logic [FRAME_W-1:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed_differing_bits=%0d expected_differing_bits=0", tag, $countones(obs ^ exp));
        end
    endtask

    // Start a transfer on instance 0 and wait (bounded) for done; stray starts at 100 and 5000.
    task automatic xfer0(input logic [MSG_W-1:0] m, input logic [KEY_W-1:0] kk,
                         output int done_k, output logic cs_ok, output logic busy_pre);
        msg_in = m;
        key_in = kk;
        start  = 1'b1;
        @(posedge clk); #1;
        start   = 1'b0;
        msg_in  = ~m;
        key_in  = ~kk;
        done_k  = -1;
        cs_ok   = 1'b1;
        busy_pre = 1'b0;
        for (int k = 1; k <= 9000 && done_k < 0; k++) begin
            @(posedge clk); #1;
            start = (k == 99) || (k == 4999);
            if (g_dut[0].done) begin
                done_k = k;
            end else begin
                cs_ok    = cs_ok && !g_dut[0].cs;
                busy_pre = g_dut[0].busy;
            end
        end
        start = 1'b0;
    endtask

    logic [MSG_W-1:0] msg1, msg2, resp1, resp2;
    logic [KEY_W-1:0] key1, key2;
    int               dk, d1, d5;
    logic             cs_ok, busy_pre;

    initial begin
        msg1  = 128'h00112233445566778899aabbccddeeff;
        resp1 = 128'h8ea2b7ca516745bfeafc49904b496089;
        msg2  = 128'hffeeddccbbaa99887766554433221100;
        resp2 = 128'h3ad77bb40d7a3660a89ecaf32466ef97;
        for (int i = 0; i < int'(KEY_W / 8); i++) key1[KEY_W - 1 - 8 * i -: 8] = 8'(i);
        key2    = ~key1;
        resp    = resp1;
        msg_in  = msg1;
        key_in  = key1;
        start_x = 1'b0;

        // Reset held with start asserted must not launch a transfer.
        rst   = 1'b1;
        start = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("rst_busy_start_held", MSG_W'(g_dut[0].busy), MSG_W'(0));
        chk("rst_cs_start_held", MSG_W'(g_dut[0].cs), MSG_W'(1));
        start = 1'b0;
        rst   = 1'b0;
        @(posedge clk); #1;
        chk("rst_sclk", MSG_W'(g_dut[0].sclk), MSG_W'(0));
        chk("rst_sdi", MSG_W'(g_dut[0].sdi), MSG_W'(0));
        chk("rst_cs", MSG_W'(g_dut[0].cs), MSG_W'(1));
        chk("rst_busy", MSG_W'(g_dut[0].busy), MSG_W'(0));
        chk("rst_done", MSG_W'(g_dut[0].done), MSG_W'(0));
        chk("rst_msg_out", g_dut[0].msg_out, MSG_W'(0));

        // Full transfer with stray starts mid-flight.
        xfer0(msg1, key1, dk, cs_ok, busy_pre);
        chk("x1_done_cycle", MSG_W'(dk), MSG_W'(8801));
        chk("x1_msg_out", g_dut[0].msg_out, resp1);
        chk("x1_busy_at_done", MSG_W'(g_dut[0].busy), MSG_W'(0));
        chk("x1_busy_before_done", MSG_W'(busy_pre), MSG_W'(1));
        chk("x1_cs_low_throughout", MSG_W'(cs_ok), MSG_W'(1));
        chk("x1_cs_at_done", MSG_W'(g_dut[0].cs), MSG_W'(1));
        chk("x1_sclk_at_done", MSG_W'(g_dut[0].sclk), MSG_W'(0));
        chk("x1_fall_count", MSG_W'(g_dut[0].fall_n), MSG_W'(2200));
        chk_frame("x1_captured_frame", g_dut[0].cap, {msg1, key1});

        // Back-to-back start in the done cycle.
        resp  = resp2;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("b2b_done_one_cycle", MSG_W'(g_dut[0].done), MSG_W'(0));
        chk("b2b_cs_low", MSG_W'(g_dut[0].cs), MSG_W'(0));
        chk("b2b_busy", MSG_W'(g_dut[0].busy), MSG_W'(1));
        chk("x1_single_done", MSG_W'(g_dut[0].done_n), MSG_W'(1));

        // Reset during SEND around bit 500 aborts with no done.
        repeat (1999) @(posedge clk);
        #1;
        chk("abort_busy_before", MSG_W'(g_dut[0].busy), MSG_W'(1));
        rst = 1'b1;
        @(posedge clk); #1;
        chk("abort_sclk", MSG_W'(g_dut[0].sclk), MSG_W'(0));
        chk("abort_sdi", MSG_W'(g_dut[0].sdi), MSG_W'(0));
        chk("abort_cs", MSG_W'(g_dut[0].cs), MSG_W'(1));
        chk("abort_busy", MSG_W'(g_dut[0].busy), MSG_W'(0));
        chk("abort_done", MSG_W'(g_dut[0].done), MSG_W'(0));
        chk("abort_msg_out", g_dut[0].msg_out, MSG_W'(0));
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("abort_no_done", MSG_W'(g_dut[0].done_n), MSG_W'(1));

        // Fresh transfer after the abort.
        xfer0(msg2, key2, dk, cs_ok, busy_pre);
        chk("x2_done_cycle", MSG_W'(dk), MSG_W'(8801));
        chk("x2_msg_out", g_dut[0].msg_out, resp2);
        chk("x2_cs_low_throughout", MSG_W'(cs_ok), MSG_W'(1));
        chk_frame("x2_captured_frame", g_dut[0].cap, {msg2, key2});
        @(posedge clk); #1;
        chk("x2_done_one_cycle", MSG_W'(g_dut[0].done), MSG_W'(0));

        // Other divider settings.
        resp    = resp1;
        msg_in  = msg1;
        key_in  = key1;
        start_x = 1'b1;
        @(posedge clk); #1;
        start_x = 1'b0;
        msg_in  = msg2;
        d1 = -1;
        d5 = -1;
        for (int k = 1; k <= 23000 && (d1 < 0 || d5 < 0); k++) begin
            @(posedge clk); #1;
            if (g_dut[1].done && d1 < 0) d1 = k;
            if (g_dut[2].done && d5 < 0) d5 = k;
        end
        chk("div1_done_cycle", MSG_W'(d1), MSG_W'(4401));
        chk("div5_done_cycle", MSG_W'(d5), MSG_W'(22001));
        chk("div1_msg_out", g_dut[1].msg_out, resp1);
        chk("div5_msg_out", g_dut[2].msg_out, resp1);
        chk_frame("div1_captured_frame", g_dut[1].cap, {msg1, key1});
        chk_frame("div5_captured_frame", g_dut[2].cap, {msg1, key1});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
